// File: rtl/echo_pkg.sv
// Shared types and constants for the echo accelerator DMA master.
// Optional saturation is selected with the ECHO_SATURATE_EN macro (see echo_mix).
package echo_pkg;

    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned SAMPLE_WIDTH = 16;
    localparam int unsigned NUM_WIDTH    = 11;
    localparam int unsigned SIZE_WIDTH   = 19;

    localparam logic [SAMPLE_WIDTH-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [SAMPLE_WIDTH-1:0] SAT_MIN = 16'h8000;

    // Byte strides: one 32-bit word per input sample, two words per output pair.
    localparam logic [DATA_WIDTH-1:0] WORD_STRIDE = 32'd4;
    localparam logic [DATA_WIDTH-1:0] PAIR_STRIDE = 32'd8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_L,
        ST_RD_R,
        ST_RD_DL,
        ST_RD_DR,
        ST_WR_L,
        ST_WR_R,
        ST_NEXT,
        ST_FIN
    } state_e;

    function automatic logic [DATA_WIDTH-1:0] sext_sample(input logic [SAMPLE_WIDTH-1:0] s);
        return {{(DATA_WIDTH - SAMPLE_WIDTH){s[SAMPLE_WIDTH-1]}}, s};
    endfunction

endpackage

// File: rtl/echo_dma_master_if.sv
// Avalon-MM master bus bundle used between the echo DMA master and memory.
interface echo_dma_master_if;
    import echo_pkg::*;

    logic [DATA_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );

endinterface

// File: rtl/echo_mix.sv
// One-channel echo mixer: y = x + (dly >>> 1), wrapping or, with
// ECHO_SATURATE_EN defined, clamped to the signed 16-bit range.
module echo_mix
    import echo_pkg::*;
(
    input  logic [SAMPLE_WIDTH-1:0] x,
    input  logic [SAMPLE_WIDTH-1:0] dly,
    output logic [SAMPLE_WIDTH-1:0] y_c
);

    localparam int unsigned SW = SAMPLE_WIDTH;

    logic [SW-1:0] half;

    assign half = {dly[SW-1], dly[SW-1:1]};

`ifdef ECHO_SATURATE_EN
    logic [SW:0] sum;

    // Overflow shows up as the two top bits of the widened sum disagreeing.
    always_comb begin
        sum = {x[SW-1], x} + {half[SW-1], half};
        if (sum[SW] != sum[SW-1]) begin
            y_c = sum[SW] ? SAT_MIN : SAT_MAX;
        end else begin
            y_c = sum[SW-1:0];
        end
    end
`else
    assign y_c = x + half;
`endif

endmodule

// File: rtl/echo_dma_master.sv
// Avalon-MM master of the audio echo accelerator: reads L/R samples and their
// delayed copies, mixes them and writes interleaved stereo. Macro: ECHO_SATURATE_EN.
module echo_dma_master
    import echo_pkg::*;
(
    input  logic                  CSI_CLOCK_CLK,
    input  logic                  CSI_CLOCK_RESET,
    input  logic                  START,
    input  logic [NUM_WIDTH-1:0]  NUM,
    input  logic [SIZE_WIDTH-1:0] SIZE,
    input  logic [DATA_WIDTH-1:0] RADDR,
    input  logic [DATA_WIDTH-1:0] LADDR,
    input  logic [DATA_WIDTH-1:0] WADDR,
    output logic                  INIT_START,
    output logic                  DONE,
    echo_dma_master_if.master     avm
);

    state_e                  state_q, state_d;
    logic [SIZE_WIDTH-1:0]   idx_q, idx_d;
    logic [SAMPLE_WIDTH-1:0] x_l_q, x_l_d, x_r_q, x_r_d;
    logic [SAMPLE_WIDTH-1:0] d_l_q, d_l_d, d_r_q, d_r_d;
    logic [DATA_WIDTH-1:0]   address_q, address_d;
    logic [DATA_WIDTH-1:0]   writedata_q, writedata_d;
    logic                    read_q, read_d;
    logic                    write_q, write_d;
    logic                    done_q, done_d;

    logic [SAMPLE_WIDTH-1:0] rd_sample;
    logic [SAMPLE_WIDTH-1:0] y_l_c, y_r_c;
    logic                    echo_active;
    logic [DATA_WIDTH-1:0]   word_off, dly_off, pair_off;
    logic                    unused_readdata_hi;

    assign rd_sample          = avm.readdata[SAMPLE_WIDTH-1:0];
    assign unused_readdata_hi = ^avm.readdata[DATA_WIDTH-1:SAMPLE_WIDTH];
    assign echo_active        = (NUM != '0) && (idx_q >= SIZE_WIDTH'(NUM));

    echo_mix u_mix_l (.x(x_l_q), .dly(d_l_q), .y_c(y_l_c));
    echo_mix u_mix_r (.x(x_r_q), .dly(d_r_q), .y_c(y_r_c));

    // State and datapath registers.
    always_ff @(posedge CSI_CLOCK_CLK) begin
        if (!CSI_CLOCK_RESET) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            x_l_q       <= '0;
            x_r_q       <= '0;
            d_l_q       <= '0;
            d_r_q       <= '0;
            address_q   <= '0;
            writedata_q <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_l_q       <= x_l_d;
            x_r_q       <= x_r_d;
            d_l_q       <= d_l_d;
            d_r_q       <= d_r_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            read_q      <= read_d;
            write_q     <= write_d;
            done_q      <= done_d;
        end
    end

    // Next state, index and sample capture; every bus state holds on waitrequest.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_l_d   = x_l_q;
        x_r_d   = x_r_q;
        d_l_d   = d_l_q;
        d_r_d   = d_r_q;
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    idx_d   = '0;
                    d_l_d   = '0;
                    d_r_d   = '0;
                    state_d = (SIZE == '0) ? ST_FIN : ST_RD_L;
                end
            end
            ST_RD_L: begin
                if (!avm.waitrequest) begin
                    x_l_d   = rd_sample;
                    state_d = ST_RD_R;
                end
            end
            ST_RD_R: begin
                if (!avm.waitrequest) begin
                    x_r_d   = rd_sample;
                    state_d = echo_active ? ST_RD_DL : ST_WR_L;
                end
            end
            ST_RD_DL: begin
                if (!avm.waitrequest) begin
                    d_l_d   = rd_sample;
                    state_d = ST_RD_DR;
                end
            end
            ST_RD_DR: begin
                if (!avm.waitrequest) begin
                    d_r_d   = rd_sample;
                    state_d = ST_WR_L;
                end
            end
            ST_WR_L: begin
                if (!avm.waitrequest) state_d = ST_WR_R;
            end
            ST_WR_R: begin
                if (!avm.waitrequest) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                // Delayed terms default to zero for the next sample.
                idx_d   = idx_q + SIZE_WIDTH'(1);
                d_l_d   = '0;
                d_r_d   = '0;
                state_d = (idx_d == SIZE) ? ST_FIN : ST_RD_L;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are registered from the state being entered.
    always_comb begin
        read_d      = 1'b0;
        write_d     = 1'b0;
        done_d      = 1'b0;
        address_d   = address_q;
        writedata_d = writedata_q;
        word_off    = DATA_WIDTH'(idx_d) * WORD_STRIDE;
        dly_off     = DATA_WIDTH'(idx_d - SIZE_WIDTH'(NUM)) * WORD_STRIDE;
        pair_off    = DATA_WIDTH'(idx_d) * PAIR_STRIDE;
        unique case (state_d)
            ST_RD_L: begin
                read_d    = 1'b1;
                address_d = LADDR + word_off;
            end
            ST_RD_R: begin
                read_d    = 1'b1;
                address_d = RADDR + word_off;
            end
            ST_RD_DL: begin
                read_d    = 1'b1;
                address_d = LADDR + dly_off;
            end
            ST_RD_DR: begin
                read_d    = 1'b1;
                address_d = RADDR + dly_off;
            end
            ST_WR_L: begin
                write_d     = 1'b1;
                address_d   = WADDR + pair_off;
                writedata_d = sext_sample(y_l_c);
            end
            ST_WR_R: begin
                write_d     = 1'b1;
                address_d   = WADDR + pair_off + WORD_STRIDE;
                writedata_d = sext_sample(y_r_c);
            end
            ST_FIN:  done_d = 1'b1;
            default: ;
        endcase
    end

    assign INIT_START    = CSI_CLOCK_RESET && (state_q == ST_IDLE) && START;
    assign DONE          = done_q;
    assign avm.address   = address_q;
    assign avm.read      = read_q;
    assign avm.write     = write_q;
    assign avm.writedata = writedata_q;

endmodule

// File: tb/tb_echo_dma_master.sv
// Self-checking bench for echo_dma_master: memory responder with optional random
// stalls, integer reference mixer, directed and randomized runs.
module tb_echo_dma_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] num = '0;
    logic [18:0] size = '0;
    logic [31:0] raddr = '0, laddr = '0, waddr = '0;
    logic        init_start, done;

    echo_dma_master_if avm ();

    echo_dma_master dut (
        .CSI_CLOCK_CLK   (clk),
        .CSI_CLOCK_RESET (rst_n),
        .START           (start),
        .NUM             (num),
        .SIZE            (size),
        .RADDR           (raddr),
        .LADDR           (laddr),
        .WADDR           (waddr),
        .INIT_START      (init_start),
        .DONE            (done),
        .avm             (avm)
    );

    always #5 clk = ~clk;

    logic [31:0] in_mem  [logic [31:0]];
    logic [31:0] out_mem [logic [31:0]];

    int unsigned n_init = 0, n_done = 0, n_rd = 0, n_wr = 0, n_strobe = 0;
    int unsigned n_unstable = 0, n_both = 0;
    bit          stall_en = 1'b0;
    bit          in_xfer = 1'b0, stalled = 1'b0;
    int          stall_left = 0;
    logic [65:0] snap = '0;

    int n_chk = 0;
    int n_fail = 0;

    // Memory slave: responds mid-cycle, commits on the following rising edge.
    always @(negedge clk) begin
        if (init_start === 1'b1) n_init++;
        if (done === 1'b1) n_done++;
        if (avm.read === 1'b1 && avm.write === 1'b1) n_both++;
        if (avm.read === 1'b1 || avm.write === 1'b1) begin
            n_strobe++;
            if (stalled && {avm.address, avm.read, avm.write, avm.writedata} !== snap) n_unstable++;
            if (!in_xfer) begin
                in_xfer    = 1'b1;
                stall_left = stall_en ? int'($urandom_range(3, 0)) : 0;
            end
            avm.readdata = in_mem.exists(avm.address) ? in_mem[avm.address] : 32'h0;
            if (stall_left > 0) begin
                stall_left--;
                avm.waitrequest = 1'b1;
                stalled = 1'b1;
                snap = {avm.address, avm.read, avm.write, avm.writedata};
            end else begin
                avm.waitrequest = 1'b0;
                stalled = 1'b0;
                in_xfer = 1'b0;
                if (avm.write) begin
                    out_mem[avm.address] = avm.writedata;
                    n_wr++;
                end else begin
                    n_rd++;
                end
            end
        end else begin
            avm.waitrequest = 1'b0;
            avm.readdata    = 32'h0;
            in_xfer = 1'b0;
            stalled = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mix(input int x, input int d);
        int s;
        s = x + (d >>> 1);
`ifdef ECHO_SATURATE_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 32'(s);
`else
        begin
            logic [15:0] w;
            w = 16'(s);
            return {{16{w[15]}}, w};
        end
`endif
    endfunction

    function automatic logic [31:0] out_rd(input logic [31:0] a);
        return out_mem.exists(a) ? out_mem[a] : 32'hxxxxxxxx;
    endfunction

    function automatic int rnd_sample();
        logic signed [15:0] v;
        v = $signed(16'($urandom));
        return int'(v);
    endfunction

    task automatic load_inputs(input int sz, input logic [31:0] la, input logic [31:0] ra,
                               input int lq[$], input int rq[$]);
        for (int k = 0; k < sz; k++) begin
            in_mem[la + 32'(4 * k)] = {16'($urandom), 16'(lq[k])};
            in_mem[ra + 32'(4 * k)] = {16'($urandom), 16'(rq[k])};
        end
    endtask

    // Full job: start, wait for DONE, then compare counts and outputs to the model.
    task automatic run_job(input string tag, input int sz, input int nm,
                           input logic [31:0] la, input logic [31:0] ra, input logic [31:0] wa,
                           input bit stl, input int lq[$], input int rq[$]);
        int unsigned i0, d0, r0, w0;
        int  cyc, n_echo;
        bit  got;
        n_echo = 0;
        for (int k = 0; k < sz; k++) if (nm != 0 && k >= nm) n_echo++;
        load_inputs(sz, la, ra, lq, rq);
        i0 = n_init; d0 = n_done; r0 = n_rd; w0 = n_wr;
        @(posedge clk); #1;
        size = 19'(sz); num = 11'(nm); laddr = la; raddr = ra; waddr = wa;
        stall_en = stl; start = 1'b1;
        @(negedge clk);
        check({tag, "_init_start"}, 32'(init_start), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && sz > 0)
                check({tag, "_first_rd"}, avm.read ? avm.address : ~la, la);
            if (done === 1'b1) got = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        if (!stl) check({tag, "_done_latency"}, 32'(cyc), 32'(1 + 5 * sz + 2 * n_echo));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_n_init"}, n_init - i0, 32'd1);
        check({tag, "_n_done"}, n_done - d0, 32'd1);
        check({tag, "_n_rd"}, n_rd - r0, 32'(2 * sz + 2 * n_echo));
        check({tag, "_n_wr"}, n_wr - w0, 32'(2 * sz));
        for (int k = 0; k < sz; k++) begin
            int dl, dr;
            dl = (nm != 0 && k >= nm) ? lq[k - nm] : 0;
            dr = (nm != 0 && k >= nm) ? rq[k - nm] : 0;
            check($sformatf("%s_yl%0d", tag, k), out_rd(wa + 32'(8 * k)), ref_mix(lq[k], dl));
            check($sformatf("%s_yr%0d", tag, k), out_rd(wa + 32'(8 * k + 4)), ref_mix(rq[k], dr));
        end
    endtask

    initial begin
        int lq[$], rq[$];
        int unsigned d0, s0;
        int  cyc, sz, nm;
        bit  found;

        repeat (3) @(negedge clk);
        check("rst_read", 32'(avm.read), 32'd0);
        check("rst_write", 32'(avm.write), 32'd0);
        check("rst_address", avm.address, 32'd0);
        check("rst_writedata", avm.writedata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_init", 32'(init_start), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        lq = '{1, 2, 3, 4};
        rq = '{-1, -2, -3, -4};
        run_job("basic", 4, 0, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 1'b0, lq, rq);
        check("basic_w5", out_rd(32'h0000_3000 + 32'd20), 32'hFFFF_FFFD);

        lq = '{100, 200, 300, 400};
        rq = '{0, 0, 0, 0};
        run_job("echo2", 4, 2, 32'h0001_0000, 32'h0001_1000, 32'h0001_2000, 1'b0, lq, rq);
        check("echo2_l2", out_rd(32'h0001_2000 + 32'd16), 32'd350);

        lq = '{30000, 30000};
        rq = '{-30000, -30000};
        run_job("sat", 2, 1, 32'h0002_0000, 32'h0002_1000, 32'h0002_2000, 1'b0, lq, rq);
`ifdef ECHO_SATURATE_EN
        check("sat_l1", out_rd(32'h0002_2008), 32'h0000_7FFF);
        check("sat_r1", out_rd(32'h0002_200C), 32'hFFFF_8000);
`else
        check("sat_l1", out_rd(32'h0002_2008), 32'hFFFF_AFC8);
        check("sat_r1", out_rd(32'h0002_200C), 32'h0000_5038);
`endif

        lq = {};
        rq = {};
        for (int k = 0; k < 8; k++) begin
            lq.push_back(rnd_sample());
            rq.push_back(rnd_sample());
        end
        run_job("stall", 8, 3, 32'h0003_0000, 32'h0003_1000, 32'h0003_2000, 1'b1, lq, rq);

        s0 = n_strobe;
        lq = {};
        rq = {};
        run_job("size0", 0, 2, 32'h0004_0000, 32'h0004_1000, 32'h0004_2000, 1'b0, lq, rq);
        check("size0_no_strobe", n_strobe - s0, 32'd0);

        // Reset asserted while WR_L of sample 2 is on the bus.
        lq = '{5, 6, 7, 8};
        rq = '{9, 10, 11, 12};
        load_inputs(4, 32'h0005_0000, 32'h0005_1000, lq, rq);
        @(posedge clk); #1;
        size = 19'd4; num = 11'd0; laddr = 32'h0005_0000; raddr = 32'h0005_1000;
        waddr = 32'h0005_2000; stall_en = 1'b0; start = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (avm.write === 1'b1 && avm.address === 32'h0005_2010) found = 1'b1;
        end
        check("mid_rst_hit_wrl", 32'(found), 32'd1);
        d0 = n_done;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_read", 32'(avm.read), 32'd0);
        check("mid_rst_write", 32'(avm.write), 32'd0);
        check("mid_rst_address", avm.address, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_rst_no_done", n_done - d0, 32'd0);
        check("mid_rst_idle", 32'(avm.read | avm.write), 32'd0);
        run_job("restart", 4, 0, 32'h0005_0000, 32'h0005_1000, 32'h0006_2000, 1'b0, lq, rq);

        // Randomized job with the output region wrapping past 2^32.
        sz = int'($urandom_range(12, 5));
        nm = int'($urandom_range(4, 0));
        lq = {};
        rq = {};
        for (int k = 0; k < sz; k++) begin
            lq.push_back(rnd_sample());
            rq.push_back(rnd_sample());
        end
        run_job("rand_wrap", sz, nm, 32'h0007_0000, 32'h0007_1000, 32'hFFFF_FFE0, 1'b1, lq, rq);

        check("bus_stable_in_stall", n_unstable, 32'd0);
        check("single_strobe", n_both, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_dma_master.md
# echo_dma_master

Avalon-MM master engine of the audio echo accelerator. It takes the START/NUM/SIZE/RADDR/LADDR/WADDR fields from the accelerator's control-register slave. It fetches left- and right-channel samples plus their delayed copies from memory, mixes `y[i] = x[i] + (x[i-NUM] >>> 1)`, and writes interleaved stereo output. It returns the INIT_START and DONE pulses to the control slave, which clear the start bit and set the done flag.

## Interface
- AVM_AVALONMASTER_DATA_WIDTH, 32, bus data width and address width.
- SAMPLE_WIDTH, 16, signed sample width held in `readdata[15:0]`.

- CSI_CLOCK_CLK  in  1  sole clock, rising edge.
- CSI_CLOCK_RESET  in  1  synchronous, active-low reset.
- START  in  1  run request (level) from the control slave.
- NUM  in  11  echo delay in samples; 0 disables the echo.
- SIZE  in  19  samples per channel.
- RADDR / LADDR / WADDR  in  32 each  byte base addresses of the right input, left input and interleaved output.
- INIT_START  out  1  one-cycle pulse when START is accepted.
- DONE  out  1  one-cycle pulse when the run completes.
- AVM_AVALONMASTER_ADDRESS  out  32  byte address.
- AVM_AVALONMASTER_READ / _WRITE  out  1 each  transfer strobes.
- AVM_AVALONMASTER_WRITEDATA  out  32  output sample, sign-extended.
- AVM_AVALONMASTER_READDATA  in  32  read data, valid in the cycle READ=1 and WAITREQUEST=0.
- AVM_AVALONMASTER_WAITREQUEST  in  1  stall.

## Operation
- States: IDLE, RD_L, RD_R, RD_DL, RD_DR, WR_L, WR_R, NEXT, FIN.
- IDLE with START=1:
  - Pulse INIT_START.
  - Clear index i.
  - If SIZE==0, go to FIN; otherwise go to RD_L.
- RD_L reads LADDR+4i. RD_R reads RADDR+4i.
- After RD_R:
  - If NUM!=0 and i>=NUM, go to RD_DL (LADDR+4(i-NUM)), then RD_DR (RADDR+4(i-NUM)).
  - Otherwise the delayed term is 0.
- WR_L writes yL to WADDR+8i. WR_R writes yR to WADDR+8i+4.
- NEXT increments i. If i+1==SIZE, go to FIN; otherwise go to RD_L.
- FIN pulses DONE for one cycle, then returns to IDLE. START has already been cleared by the slave, so no automatic restart occurs.
- Mix arithmetic:
  - Operands: the 16-bit signed `readdata[15:0]`; the delayed operand is arithmetic-shifted right by 1.
  - Sum is computed at 17 bits, then reduced to 16 bits (see Configuration) and sign-extended to 32.
- Address arithmetic is modulo 2^32; wrap-around is silent.
- Only one strobe (READ or WRITE) is asserted at a time. No bursts and no pipelined reads.

## Timing
- Reset values:
  - State IDLE, i=0.
  - INIT_START=0, DONE=0.
  - READ=0, WRITE=0.
  - ADDRESS=0, WRITEDATA=0.
  - Sample registers 0.
- Each read or write state holds ADDRESS, the strobe and WRITEDATA stable while WAITREQUEST=1. The state advances on the first edge with WAITREQUEST=0. Read data is captured on that same edge.
- Zero-wait throughput: 5 cycles per sample without the echo term, 7 with it, plus FIN.
- INIT_START is asserted in the first cycle START is seen in IDLE. DONE is asserted in the cycle after the final WR_R completes.
- START is ignored outside IDLE.
- Reset asserted mid-run:
  - Next edge returns to IDLE with strobes deasserted.
  - No DONE pulse.
  - Any partial output stays in memory.
- NUM changes mid-run are sampled live; software must hold the fields stable while running.

## Configuration
- ECHO_SATURATE_EN defined: the 17-bit sum clamps to [-32768, 32767].
- ECHO_SATURATE_EN undefined: the sum wraps, keeping the low 16 bits.

## Structure
- Package `echo_pkg`:
  - State enum.
  - SAMPLE_WIDTH, SAT_MAX = 16'h7FFF, SAT_MIN = 16'h8000.
  - Byte-stride constants 4 and 8.
- Sub-module `echo_mix`: combinational shift/add/saturate on one channel, instantiated twice (L and R).
- The FSM, index counter and address generation stay in the top module.

## Test plan
- SIZE=4, NUM=0, WAITREQUEST=0, L={1,2,3,4}, R={-1,-2,-3,-4} -> out words {1,-1,2,-2,3,-3,4,-4} at WADDR..WADDR+28; DONE exactly 21 cycles after INIT_START; one INIT_START pulse.
- SIZE=4, NUM=2, L={100,200,300,400}, R=0 -> L outputs {100,200,350,500}; RD_DL/RD_DR issued only for i=2,3.
- L[0]=30000, L[1]=30000, NUM=1 -> with ECHO_SATURATE_EN out L[1]=32767; without it, -20536 (sign-extended).
- Random 0–3 cycle WAITREQUEST stalls on SIZE=8, NUM=3 -> output matches the zero-stall golden model; ADDRESS, strobes and WRITEDATA stable during every stall.
- SIZE=0 with START -> INIT_START then DONE on the following cycle; no READ/WRITE ever asserted.
- Reset asserted during WR_L of sample 2 -> next cycle IDLE, strobes 0, no DONE; a new START restarts from i=0.
